// File: rtl/tag_sched_pkg.sv
// Shared types and constants for the tag generation scheduler.
package tag_sched_pkg;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Secret key width and its value out of reset.
  localparam int          KEY_W   = 16;
  localparam logic [15:0] KEY_RST = 16'h0000;

  // Mismatch counter width and its saturation value.
  localparam int          ERR_W   = 16;
  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  // Number of data blocks folded into one tag.
  localparam int          NUM_BLOCKS = 4;

endpackage

// File: rtl/tag_gen_core.sv
// Combinational tag function: each of the four data blocks is optionally
// inverted and rotated under control of the key, then all four are XORed.
module tag_gen_core
  import tag_sched_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int BLOCK_SIZE = DATA_SIZE / 4
) (
  input  logic [DATA_SIZE-1:0]  data,
  input  logic [KEY_W-1:0]      key,
  output logic [BLOCK_SIZE-1:0] tag
);

  // Key bits 0..3 select inversion and bits 0..11 select the rotate amounts;
  // the top nibble has no role in the tag function.
  logic unused_key_bits;
  assign unused_key_bits = ^key[KEY_W-1:3*NUM_BLOCKS];

  // Fold the four transformed blocks together. The rotate uses a doubled
  // copy of the block so a zero amount is a plain identity (no shift by width).
  always_comb begin
    logic [BLOCK_SIZE-1:0]   blk;
    logic [2*BLOCK_SIZE-1:0] dbl;
    int                      amt;
    tag = '0;
    blk = '0;
    dbl = '0;
    amt = 0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      blk = data[i*BLOCK_SIZE +: BLOCK_SIZE];
      if (key[i]) begin
        blk = ~blk;
      end
      amt = int'(key[3*i +: 3]) % BLOCK_SIZE;
      dbl = {blk, blk} << amt;
      tag = tag ^ dbl[2*BLOCK_SIZE-1 -: BLOCK_SIZE];
    end
  end

endmodule

// File: rtl/tag_gen_scheduler.sv
// Round-robin scheduler sharing one tag_gen_core between NUM_REQ requesters.
//
// Handshake rule (request and response sides alike): a transfer happens in a
// cycle where valid and ready are both high at the rising clock edge. A
// requester keeps its valid/data stable until it sees ready; the scheduler
// holds rsp_valid and all rsp_* fields stable until rsp_ready is seen.
//
// Flow: IDLE (grant, capture operands) -> GEN (evaluate tag, register the
// response) -> RESP (wait for rsp_ready) -> IDLE. Key writes land in a shadow
// register and are only copied to the active key in IDLE, so a transaction in
// flight always sees one key.
module tag_gen_scheduler
  import tag_sched_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int BLOCK_SIZE = DATA_SIZE / 4,
  parameter int NUM_REQ    = 2,
  parameter int SRC_W      = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          key_wr_en,
  input  logic [KEY_W-1:0]              key_wr_data,
  output logic                          key_busy,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_SIZE-1:0]  req_data,
  input  logic [NUM_REQ-1:0]            req_check,
  input  logic [NUM_REQ*BLOCK_SIZE-1:0] req_tag_exp,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [SRC_W-1:0]              rsp_src,
  output logic [BLOCK_SIZE-1:0]         rsp_tag,
  output logic                          rsp_mismatch,
  output logic [ERR_W-1:0]              err_count,
  output logic [1:0]                    dbg_state
);

  state_t                state;
  logic [SRC_W-1:0]      rr_ptr;

  logic [KEY_W-1:0]      active_key;
  logic [KEY_W-1:0]      shadow_key;
  logic                  key_pending;

  logic [DATA_SIZE-1:0]  op_data;
  logic                  op_check;
  logic [BLOCK_SIZE-1:0] op_exp;
  logic [SRC_W-1:0]      op_src;

  logic                  grant_found;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant_en;
  logic [SRC_W-1:0]      next_rr;

  logic [DATA_SIZE-1:0]  sel_data;
  logic                  sel_check;
  logic [BLOCK_SIZE-1:0] sel_exp;

  logic [BLOCK_SIZE-1:0] core_tag;

  assign key_busy  = key_pending;
  assign dbg_state = state;

  // Cyclic priority search: first valid requester at or after rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && req_valid[i] &&
            (i == ((int'(rr_ptr) + off) % NUM_REQ))) begin
          grant_found = 1'b1;
          grant_idx   = SRC_W'(i);
        end
      end
    end
  end

  // A grant is only issued in IDLE, and not in a cycle that applies a key.
  assign grant_en = (state == S_IDLE) && !key_pending && grant_found;

  // Pointer moves just past the winner so it gets lowest priority next time.
  always_comb begin
    if (int'(grant_idx) >= NUM_REQ - 1) begin
      next_rr = '0;
    end else begin
      next_rr = grant_idx + SRC_W'(1);
    end
  end

  // One-hot ready toward the winning requester, zero otherwise.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_en && (grant_idx == SRC_W'(i));
    end
  end

  // Select the winning requester's operand slices.
  always_comb begin
    sel_data  = '0;
    sel_check = 1'b0;
    sel_exp   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_data  = req_data[i*DATA_SIZE +: DATA_SIZE];
        sel_check = req_check[i];
        sel_exp   = req_tag_exp[i*BLOCK_SIZE +: BLOCK_SIZE];
      end
    end
  end

  tag_gen_core #(
    .DATA_SIZE  (DATA_SIZE),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_core (
    .data (op_data),
    .key  (active_key),
    .tag  (core_tag)
  );

  // Key shadow: a write may arrive any time; it is applied only in IDLE.
  // A write coinciding with an apply keeps the new value pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_key  <= KEY_RST;
      shadow_key  <= KEY_RST;
      key_pending <= 1'b0;
    end else begin
      if ((state == S_IDLE) && key_pending) begin
        active_key  <= shadow_key;
        key_pending <= 1'b0;
      end
      if (key_wr_en) begin
        shadow_key  <= key_wr_data;
        key_pending <= 1'b1;
      end
    end
  end

  // Transaction FSM with operand capture, registered response and error count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      op_data      <= '0;
      op_check     <= 1'b0;
      op_exp       <= '0;
      op_src       <= '0;
      rsp_valid    <= 1'b0;
      rsp_src      <= '0;
      rsp_tag      <= '0;
      rsp_mismatch <= 1'b0;
      err_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_en) begin
            op_data  <= sel_data;
            op_check <= sel_check;
            op_exp   <= sel_exp;
            op_src   <= grant_idx;
            rr_ptr   <= next_rr;
            state    <= S_GEN;
          end
        end
        S_GEN: begin
          rsp_tag      <= core_tag;
          rsp_mismatch <= op_check && (core_tag != op_exp);
          rsp_src      <= op_src;
          rsp_valid    <= 1'b1;
          state        <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_mismatch && (err_count != ERR_MAX)) begin
              err_count <= err_count + 16'd1;
            end
            state <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tag_gen_scheduler.sv
// Directed bench for tag_gen_scheduler: reset, generate/check, backpressure,
// round-robin order, key timing and reset during a response.
module tb_tag_gen_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        key_wr_en;
  logic [15:0] key_wr_data;
  logic        key_busy;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_data;
  logic [1:0]  req_check;
  logic [15:0] req_tag_exp;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_src;
  logic [7:0]  rsp_tag;
  logic        rsp_mismatch;
  logic [15:0] err_count;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int errors  = 0;

  // Scoreboard of expected grant indices for the fairness step.
  logic [1:0] exp_q[$];

  tag_gen_scheduler #(
    .DATA_SIZE  (32),
    .BLOCK_SIZE (8),
    .NUM_REQ    (2),
    .SRC_W      (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_wr_en    (key_wr_en),
    .key_wr_data  (key_wr_data),
    .key_busy     (key_busy),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_check    (req_check),
    .req_tag_exp  (req_tag_exp),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_src      (rsp_src),
    .rsp_tag      (rsp_tag),
    .rsp_mismatch (rsp_mismatch),
    .err_count    (err_count),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] d, input logic chk, input logic [7:0] exp_tag);
    req_valid[idx]            = 1'b1;
    req_data[idx*32 +: 32]    = d;
    req_check[idx]            = chk;
    req_tag_exp[idx*8 +: 8]   = exp_tag;
  endtask

  // Full transaction with rsp_ready high; starts and ends at the start of an IDLE cycle.
  task automatic run_txn(input int idx, input logic [31:0] d, input logic chk,
                         input logic [7:0] exp_tag, input logic [7:0] want_tag,
                         input logic want_mis);
    set_req(idx, d, chk, exp_tag);
    @(negedge clk);
    check("txn_ready", 32'(req_ready), 32'd1 << idx);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("txn_gen_state", 32'(dbg_state), 32'd1);
    check("txn_gen_no_valid", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check("txn_rsp_valid", 32'(rsp_valid), 32'd1);
    check("txn_rsp_tag", 32'(rsp_tag), 32'(want_tag));
    check("txn_rsp_src", 32'(rsp_src), 32'(idx));
    check("txn_rsp_mismatch", 32'(rsp_mismatch), 32'(want_mis));
    tick();
  endtask

  // Key write from IDLE: pending for exactly one cycle, then applied.
  task automatic write_key(input logic [15:0] k);
    key_wr_en   = 1'b1;
    key_wr_data = k;
    tick();
    key_wr_en = 1'b0;
    @(negedge clk);
    check("key_busy_set", 32'(key_busy), 32'd1);
    tick();
    @(negedge clk);
    check("key_busy_clear", 32'(key_busy), 32'd0);
    tick();
  endtask

  initial begin
    int grants;
    logic [1:0] exp_g;

    // Reset.
    reset_n     = 1'b0;
    key_wr_en   = 1'b0;
    key_wr_data = '0;
    req_valid   = '0;
    req_data    = '0;
    req_check   = '0;
    req_tag_exp = '0;
    rsp_ready   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_key_busy", 32'(key_busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: key 0, generate on req0: 44^33^22^11 = 44.
    run_txn(0, 32'h11223344, 1'b0, 8'h00, 8'h44, 1'b0);

    // 2: key 0001 (invert + rotl1 on block 0 -> 77), check on req1 passes.
    write_key(16'h0001);
    run_txn(1, 32'h11223344, 1'b1, 8'h77, 8'h77, 1'b0);
    check("err_after_pass", 32'(err_count), 32'd0);

    // 3: check with exp 00 -> mismatch; hold rsp_ready low for 5 cycles.
    rsp_ready = 1'b0;
    set_req(1, 32'h11223344, 1'b1, 8'h00);
    @(negedge clk);
    check("bp_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b11;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_tag", 32'(rsp_tag), 32'h77);
      check("bp_mismatch", 32'(rsp_mismatch), 32'd1);
      check("bp_src", 32'(rsp_src), 32'd1);
      check("bp_no_ready", 32'(req_ready), 32'd0);
      check("bp_err_hold", 32'(err_count), 32'd0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_err_before_hs", 32'(err_count), 32'd0);
    tick();
    @(negedge clk);
    check("bp_err_after_hs", 32'(err_count), 32'd1);
    check("bp_valid_drop", 32'(rsp_valid), 32'd0);
    tick();

    // 4: both requesters held valid; rr_ptr is 0 after the last grant to 1.
    req_check   = '0;
    req_data    = {32'h11223344, 32'h11223344};
    exp_q       = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    req_valid   = 2'b11;
    grants      = 0;
    for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        exp_g = exp_q.pop_front();
        check("rr_grant", 32'(req_ready), 32'd1 << exp_g);
        grants++;
      end
      tick();
    end
    req_valid = '0;
    check("rr_grant_count", 32'(grants), 32'd6);
    tick();
    tick();

    // 5a: key 0F1A: rot 2/3/4/7, invert blocks 1 and 3 -> 11^66^22^77 = 22.
    write_key(16'h0F1A);
    run_txn(0, 32'h11223344, 1'b1, 8'h22, 8'h22, 1'b0);

    // 5: key writes during GEN and RESP do not affect the in-flight tag.
    set_req(0, 32'h11223344, 1'b0, 8'h00);
    @(negedge clk);
    check("kt_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid   = '0;
    key_wr_en   = 1'b1;
    key_wr_data = 16'h0001;
    tick();
    key_wr_data = 16'h0000;
    @(negedge clk);
    check("kt_old_key_tag", 32'(rsp_tag), 32'h22);
    check("kt_busy_resp", 32'(key_busy), 32'd1);
    tick();
    key_wr_en = 1'b0;
    req_valid = 2'b01;
    @(negedge clk);
    check("kt_no_grant_apply", 32'(req_ready), 32'd0);
    check("kt_busy_apply", 32'(key_busy), 32'd1);
    tick();
    @(negedge clk);
    check("kt_grant_after", 32'(req_ready), 32'h1);
    check("kt_busy_done", 32'(key_busy), 32'd0);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    check("kt_new_key_tag", 32'(rsp_tag), 32'h44);
    check("kt_new_key_valid", 32'(rsp_valid), 32'd1);
    tick();

    // 6: reset during RESP with a mismatch pending and a key write pending.
    write_key(16'h0F1A);
    rsp_ready = 1'b0;
    set_req(1, 32'h11223344, 1'b1, 8'h00);
    @(negedge clk);
    check("rr6_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid   = '0;
    key_wr_en   = 1'b1;
    key_wr_data = 16'h00FF;
    tick();
    key_wr_en = 1'b0;
    @(negedge clk);
    check("r6_valid", 32'(rsp_valid), 32'd1);
    check("r6_tag", 32'(rsp_tag), 32'h22);
    check("r6_mismatch", 32'(rsp_mismatch), 32'd1);
    check("r6_busy", 32'(key_busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("r6_valid_drop", 32'(rsp_valid), 32'd0);
    check("r6_err_clear", 32'(err_count), 32'd0);
    check("r6_busy_clear", 32'(key_busy), 32'd0);
    check("r6_state_idle", 32'(dbg_state), 32'd0);
    check("r6_tag_clear", 32'(rsp_tag), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    tick();
    // Key back to 0 gives 44 (0F1A would give 22).
    run_txn(0, 32'h11223344, 1'b0, 8'h00, 8'h44, 1'b0);
    check("r6_err_after", 32'(err_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/tag_gen_scheduler.md
Name: tag_gen_scheduler

Overview:
Shares one combinational tag datapath (tag_gen_core) between NUM_REQ requesters, e.g. a store path that generates tags and a load path that checks them. Uses round-robin arbitration with valid/ready handshakes on both the request and response sides. Owns the active 16-bit secret key, and applies key updates only between transactions. Counts tag-check mismatches for the integrity monitor.

Parameters:
DATA_SIZE, 32, data word width; must be a multiple of 4.
BLOCK_SIZE, DATA_SIZE/4, tag width; one of the four data blocks.
NUM_REQ, 2, number of requesters, 2..4.
SRC_W, 2, response source-index width; must satisfy 2^SRC_W >= NUM_REQ.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
key_wr_en  in  1  request to load a new secret key.
key_wr_data  in  16  new key value.
key_busy  out  1  a key write is pending and not yet applied.
req_valid  in  NUM_REQ  per-requester valid.
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
req_data  in  NUM_REQ*DATA_SIZE  data word; requester i uses slice [i*DATA_SIZE +: DATA_SIZE].
req_check  in  NUM_REQ  1 = check against expected tag, 0 = generate only.
req_tag_exp  in  NUM_REQ*BLOCK_SIZE  expected tag; requester i uses slice [i*BLOCK_SIZE +: BLOCK_SIZE].
rsp_valid  out  1  response valid.
rsp_ready  in  1  response accept.
rsp_src  out  SRC_W  index of the requester being answered.
rsp_tag  out  BLOCK_SIZE  computed tag.
rsp_mismatch  out  1  high when req_check=1 and computed tag != expected tag.
err_count  out  16  saturating count of delivered mismatches.

Behaviour:
- Reset (async assert, sync release) sets:
  - state = IDLE; rr_ptr = 0; active_key = 16'h0000; pending key cleared; key_busy = 0.
  - rsp_valid = 0; rsp_src, rsp_tag, rsp_mismatch = 0; err_count = 0.
  - Any in-flight transaction is dropped and no response is issued for it.
- FSM states: IDLE, GEN, RESP.
- IDLE:
  - If a key is pending: active_key <= shadow key, pending cleared. No grant in that cycle.
  - Else if any req_valid: grant the first valid index at or after rr_ptr, searching cyclically. Assert req_ready[g] in the same cycle (combinational from req_valid and state).
  - On grant, capture data, check flag, expected tag and index g into operand registers. Set rr_ptr <= (g+1) mod NUM_REQ. Go to GEN.
  - req_ready is 0 in every other state.
- GEN (1 cycle):
  - tag_gen_core evaluates the operand registers with active_key.
  - Register rsp_tag, rsp_mismatch = check & (tag != exp), and rsp_src. Go to RESP.
- RESP:
  - rsp_valid = 1. All rsp_* outputs stay stable until rsp_ready.
  - On handshake: if mismatch, err_count += 1, saturating at 16'hFFFF. Go to IDLE.
- Timing:
  - Latency: accept at cycle T, rsp_valid visible at T+2.
  - Throughput: one transaction per 3 cycles with rsp_ready tied high.
  - Backpressure stalls the block in RESP with no new grants.
- Key handling:
  - key_wr_en in any state loads the shadow register and sets pending; key_busy = pending.
  - Multiple writes before application: the last write wins.
  - The key never changes during GEN or RESP, so each transaction uses exactly one key.
  - key_wr_en in the same cycle as an IDLE apply: the old shadow is applied and the new write stays pending.
- tag_gen_core (combinational). For block i = 0..3:
  - b_i = data[i*BLOCK_SIZE +: BLOCK_SIZE].
  - Invert b_i if key[i] = 1.
  - Rotate left by key[3i+2:3i] mod BLOCK_SIZE; rotate by 0 is identity, with no shift-by-width artefact.
  - tag = XOR of the four rotated blocks.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.

Decomposition:
- Package tag_sched_pkg holds:
  - state encoding: S_IDLE = 2'd0, S_GEN = 2'd1, S_RESP = 2'd2;
  - KEY_W = 16, KEY_RST = 16'h0000, ERR_W = 16, ERR_MAX = 16'hFFFF.
- One sub-module: tag_gen_core (parameters DATA_SIZE, BLOCK_SIZE; ports data, key, tag; purely combinational).
- The arbiter, FSM, key shadow and counter stay in tag_gen_scheduler.

Test Plan:
1. Reset, key 0; req0 generate with data 32'h11223344 -> req_ready[0] same cycle; rsp_valid 2 cycles later; rsp_tag = 8'h44, rsp_src = 0, rsp_mismatch = 0.
2. key_wr 16'h0001 while idle -> key_busy 1 for one cycle. Then req1 check, data 32'h11223344, exp 8'h77 -> rsp_tag = 8'h77, mismatch 0, rsp_src = 1.
3. Same check with exp 8'h00 -> mismatch 1; err_count goes 0 -> 1 only on the rsp handshake. Hold rsp_ready low 5 cycles -> outputs stable, no new req_ready.
4. Both req_valid held high for 6 transactions -> grant order 0,1,0,1,0,1.
5. key_wr 16'h0001 during GEN, then 16'h0000 during RESP -> in-flight tag uses the old key; the next transaction uses 16'h0000; no grant in the apply cycle.
6. Assert reset_n low during RESP -> rsp_valid drops immediately, err_count = 0, key = 0. After release, IDLE accepts req0 normally.
